led_fader: RTL and testbench
============================

Name: led_fader

Overview:
- Downstream stage for the LED pattern rotator. Consumes the raw on/off LED pattern and drives the physical LED pins with PWM.
- Each LED ramps its brightness linearly toward its target (full on or off) instead of snapping, so each rotation step becomes a smooth crossfade.
- Sits between the pattern generator and the D1..D4 pad outputs.

Parameters:
NUM_LEDS, 4, number of LED channels
PWM_BITS, 8, brightness resolution; MAX = 2^PWM_BITS-1
STEP_DIV, 46875, clk cycles per brightness step (1 s full ramp at 12 MHz, 8-bit); must be >= 1

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
pattern_in  input  NUM_LEDS  target pattern; bit i=1 means LED i fades to MAX, 0 means fades to 0
pattern_valid  input  1  single-cycle strobe; latch pattern_in into target
enable  input  1  1 = fading active; 0 = brightness levels frozen
led_out  output  NUM_LEDS  registered PWM drive to pads
busy  output  1  1 while any level differs from its target endpoint

Behaviour:
- Reset (rst_n=0, asynchronous): target=0, all levels=0, pwm_cnt=0, prescaler=0, led_out=0, busy=0. Reset asserted mid-fade takes effect immediately. The first edge after deassertion resumes from these values.
- Target register: loads pattern_in on any clk edge with pattern_valid=1, otherwise holds. A new pattern mid-fade changes direction only. Levels never jump.
- PWM counter:
  - Free-runs 0..MAX-1 and wraps to 0, giving a period of MAX cycles.
  - It is independent of enable.
- Per-channel output: led_out[i] is registered from (level[i] > pwm_cnt).
  - Level 0 gives constant 0. Level MAX gives constant 1. Level L gives exactly L high cycles per MAX-cycle period.
  - Latency: a level change is visible on led_out one clk later.
- Prescaler:
  - With enable=1, counts 0..STEP_DIV-1. step_tick is asserted when count==STEP_DIV-1, and the count then wraps to 0.
  - With enable=0, the prescaler is held at 0 and there is no step_tick.
  - With STEP_DIV=1, step_tick fires every cycle.
- Level update on step_tick, for each i independently:
  - target[i]=1 and level<MAX: level+1.
  - target[i]=0 and level>0: level-1.
  - Otherwise hold. Levels saturate and never wrap.
  - Arithmetic width is PWM_BITS, unsigned.
- Simultaneous pattern_valid and step_tick: the step uses the OLD target (the current register value). The new target governs from the next step.
- busy: combinational from registers. busy = OR over i of (level[i] != (target[i] ? MAX : 0)).
  - busy rises in the cycle after a pattern_valid that changes any target bit.
  - busy falls in the same cycle the last level reaches its endpoint.
- enable=0 freezes levels and busy, but PWM output continues at the frozen levels.
- After enable rises, the first step_tick occurs STEP_DIV cycles later.
- No illegal states. All counters are self-limiting.

Test Plan:
All tests use PWM_BITS=4 (MAX=15) and STEP_DIV=4 unless noted.
- Basic fade:
  - Stimulus: reset release, enable=1, pattern_valid with pattern_in=0101.
  - Required: level0 and level2 increment every 4 cycles and reach 15 after 60 cycles. busy=1 until that cycle, then 0. Afterwards led_out=0101 constant across several PWM periods.
- Duty cycle:
  - Stimulus: fade LED0 up, then drop enable when level0=5.
  - Required: led_out[0] is high exactly 5 of every 15 cycles, repeatedly. busy stays 1 and level0 stays 5.
- Reversal:
  - Stimulus: pattern 0001; at level0=8, apply pattern 0000.
  - Required: level0 goes 8 to 7, 6, …, 0 with no jump. busy falls when 0 is reached. led_out[0] is constant 0 afterwards.
- Rotation crossfade:
  - Stimulus: pattern 0101 settled, then pattern 1010.
  - Required: channels 0 and 2 descend while channels 1 and 3 ascend in the same ticks. Level pairs always sum to 15.
- Simultaneous events:
  - Stimulus: assert pattern_valid (0000 to 0001) in the exact step_tick cycle.
  - Required: no level change on that tick. level0=1 on the next tick, 4 cycles later.
- Async reset:
  - Stimulus: assert rst_n=0 mid-fade (level=9), between clock edges.
  - Required: led_out=0 and busy=0 without waiting for a clk edge. After release, all levels are 0 and pattern_valid is required to restart.

Source files
------------

// File: rtl/led_fader.sv
// led_fader: per-channel linear brightness fader with PWM pad drive.
//
// Each LED level ramps one step per prescaler tick toward its target
// endpoint (0 or MAX), so a change of pattern crossfades instead of snapping.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   pattern_in     target pattern; bit i = 1 fades LED i to MAX, 0 fades to 0
//   pattern_valid  single-cycle strobe that latches pattern_in as the target
//   enable         1 = fading active, 0 = levels frozen (PWM keeps running)
//   led_out        registered PWM drive to the pads
//   busy           1 while any level differs from its target endpoint
module led_fader #(
  parameter int NUM_LEDS = 4,
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 46875
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_LEDS-1:0] pattern_in,
  input  logic                pattern_valid,
  input  logic                enable,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                busy
);

  localparam logic [PWM_BITS-1:0] LVL_MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((1 << PWM_BITS) - 2);
  localparam int                  PRE_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);

  logic [NUM_LEDS-1:0]                target_q,  target_d;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0]  level_q,   level_d;
  logic [PWM_BITS-1:0]                pwm_cnt_q, pwm_cnt_d;
  logic [PRE_W-1:0]                   presc_q,   presc_d;
  logic [NUM_LEDS-1:0]                led_q,     led_d;
  logic                               step_tick;

  always_comb begin
    step_tick = enable && (presc_q == PRE_LAST);

    // Prescaler sits at 0 while disabled so the first tick after enable
    // rises lands a full STEP_DIV cycles later.
    if (!enable || step_tick) presc_d = '0;
    else                      presc_d = presc_q + PRE_W'(1);

    // Period of MAX cycles: level MAX beats every count, level 0 none.
    if (pwm_cnt_q == PWM_LAST) pwm_cnt_d = '0;
    else                       pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);

    target_d = pattern_valid ? pattern_in : target_q;

    // Stepping uses target_q, so a pattern landing on a tick edge only
    // takes effect from the following tick.
    level_d = level_q;
    led_d   = '0;
    busy    = 1'b0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (step_tick) begin
        if (target_q[i] && (level_q[i] != LVL_MAX))
          level_d[i] = level_q[i] + PWM_BITS'(1);
        else if (!target_q[i] && (level_q[i] != '0))
          level_d[i] = level_q[i] - PWM_BITS'(1);
      end
      led_d[i] = (level_q[i] > pwm_cnt_q);
      if (level_q[i] != (target_q[i] ? LVL_MAX : '0)) busy = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q  <= '0;
      level_q   <= '0;
      pwm_cnt_q <= '0;
      presc_q   <= '0;
      led_q     <= '0;
    end else begin
      target_q  <= target_d;
      level_q   <= level_d;
      pwm_cnt_q <= pwm_cnt_d;
      presc_q   <= presc_d;
      led_q     <= led_d;
    end
  end

  assign led_out = led_q;

endmodule

// File: tb/tb_led_fader.sv
module tb_led_fader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pattern_in;
  logic       pattern_valid;
  logic       enable;
  logic [3:0] led_out;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int hi [4];

  led_fader #(.NUM_LEDS(4), .PWM_BITS(4), .STEP_DIV(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pattern_in    (pattern_in),
    .pattern_valid (pattern_valid),
    .enable        (enable),
    .led_out       (led_out),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // High-cycle count per channel over one 15-cycle PWM period.
  task automatic measure();
    for (int c = 0; c < 4; c++) hi[c] = 0;
    repeat (15) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) if (led_out[c]) hi[c]++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; enable = 1'b0; pattern_valid = 1'b0; pattern_in = 4'b0000;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  // Strobe a pattern (with enable raised) at a negedge; returns after E1.
  task automatic start(input logic [3:0] p);
    enable = 1'b1; pattern_in = p; pattern_valid = 1'b1;
    step(1);
    pattern_valid = 1'b0;
  endtask

  initial begin
    int errs;
    rst_n = 1'b0; enable = 1'b0; pattern_valid = 1'b0; pattern_in = 4'b0000;
    #1;
    chk("reset_led", led_out, 0);
    chk("reset_busy", busy, 0);
    do_reset();

    // Basic fade 0101: ticks at E4..E60, level 15 reached at E60.
    start(4'b0101);
    chk("fade_busy_e1", busy, 1);
    step(58);
    chk("fade_busy_e59", busy, 1);
    step(1);
    chk("fade_busy_e60", busy, 0);
    step(1);
    errs = 0;
    repeat (45) begin
      @(negedge clk);
      if (led_out !== 4'b0101) errs++;
    end
    chk("fade_led_const", errs, 0);
    chk("fade_busy_after", busy, 0);

    // Duty cycle: freeze at level 5 (E20).
    do_reset();
    start(4'b0001);
    step(19);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      measure();
      chk("duty_led0", hi[0], 5);
      chk("duty_led1", hi[1], 0);
    end
    chk("duty_busy", busy, 1);
    step(100);
    measure();
    chk("duty_frozen", hi[0], 5);
    chk("duty_busy_frozen", busy, 1);

    // Reversal at level 8 (E32); pattern 0000 loads at E33.
    do_reset();
    start(4'b0001);
    step(31);
    pattern_in = 4'b0000; pattern_valid = 1'b1;
    step(1);
    pattern_valid = 1'b0;
    chk("rev_busy_e33", busy, 1);
    step(15);                       // after E48: ticks E36..E48 -> level 4
    enable = 1'b0;
    measure();
    chk("rev_mid_level", hi[0], 4);
    enable = 1'b1;
    step(15);
    chk("rev_busy_r15", busy, 1);
    step(1);
    chk("rev_busy_r16", busy, 0);
    step(1);
    errs = 0;
    repeat (30) begin
      @(negedge clk);
      if (led_out[0] !== 1'b0) errs++;
    end
    chk("rev_led_zero", errs, 0);

    // Rotation crossfade: 0101 settled, then 1010.
    do_reset();
    start(4'b0101);
    step(59);
    chk("rot_settled", busy, 0);
    pattern_in = 4'b1010; pattern_valid = 1'b1;
    step(1);
    pattern_valid = 1'b0;
    chk("rot_busy", busy, 1);
    step(11);                       // after E72: three ticks
    enable = 1'b0;
    measure();
    chk("rot_ch0", hi[0], 12);
    chk("rot_ch1", hi[1], 3);
    chk("rot_ch2", hi[2], 12);
    chk("rot_ch3", hi[3], 3);
    chk("rot_sum", hi[0] + hi[1], 15);
    enable = 1'b1;
    step(47);
    chk("rot_busy_r47", busy, 1);
    step(1);
    chk("rot_busy_r48", busy, 0);
    step(2);
    chk("rot_led_final", led_out, 4'b1010);

    // Simultaneous pattern_valid and step_tick at E4.
    do_reset();
    enable = 1'b1;
    step(3);
    chk("sim_busy_pre", busy, 0);
    pattern_in = 4'b0001; pattern_valid = 1'b1;
    step(1);
    pattern_valid = 1'b0;
    chk("sim_busy_e4", busy, 1);
    step(4);                        // after E8: exactly one up-step
    enable = 1'b0;
    measure();
    chk("sim_level", hi[0], 1);

    // Async reset mid-fade at level 9.
    do_reset();
    start(4'b0001);
    step(36);
    chk("ar_busy_pre", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_led", led_out, 0);
    chk("ar_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    errs = 0;
    repeat (40) begin
      @(negedge clk);
      if (led_out !== 4'b0000) errs++;
    end
    chk("ar_led_after", errs, 0);
    chk("ar_busy_after", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
